// File: rtl/dll_pkg.sv
// Shared DLL types: DLCM state encoding, FC type, DLLP type codes used by FC init.
package dll_pkg;
  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_INIT1    = 2'd1,
    DL_INIT2    = 2'd2,
    DL_ACTIVE   = 2'd3
  } dlcm_state_t;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_t;

  localparam logic [3:0] INITFC1_P    = 4'h4;
  localparam logic [3:0] INITFC1_NP   = 4'h5;
  localparam logic [3:0] INITFC1_CPL  = 4'h6;
  localparam logic [3:0] INITFC2_P    = 4'hC;
  localparam logic [3:0] INITFC2_NP   = 4'hD;
  localparam logic [3:0] INITFC2_CPL  = 4'hE;
  localparam logic [3:0] UPDATEFC_P   = 4'h8;
  localparam logic [3:0] UPDATEFC_NP  = 4'h9;
  localparam logic [3:0] UPDATEFC_CPL = 4'hA;

  // InitFC codes are {fc2, 1'b1, fct}, so the set sequencer builds them from the counters.
  function automatic logic [3:0] initfc_code(input logic fc2, input fc_type_t fct);
    return {fc2, 1'b1, fct};
  endfunction
endpackage

// File: rtl/dll_fci_tx_seq.sv
// InitFC set sequencer: walks vc 0..NUM_VC-1 x {P,NP,Cpl} over a valid/ready handshake.
module dll_fci_tx_seq
  import dll_pkg::*;
#(
  parameter int NUM_VC = 1,
  parameter int HDR_W  = 8,
  parameter int DATA_W = 12
) (
  input  logic                        sclk,
  input  logic                        srst_n,
  input  logic                        clr,
  input  logic                        start,
  input  logic                        fc2_sel,
  input  logic [2:0][HDR_W-1:0]       adv_hdr,
  input  logic [2:0][DATA_W-1:0]      adv_data,
  input  logic                        tx_ready,
  output logic                        tx_valid,
  output logic [3:0]                  tx_type,
  output logic [2:0]                  tx_vc,
  output logic [HDR_W-1:0]            tx_hdr,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        set_done
);
  logic [2:0] vc_q, nxt_vc;
  fc_type_t   fct_q, nxt_fct;
  logic       fc2_q, xfer, last;

  assign xfer     = tx_valid & tx_ready;
  assign last     = (vc_q == 3'(NUM_VC-1)) && (fct_q == FC_CPL);
  assign set_done = xfer & last;

  always_comb begin
    nxt_fct = (fct_q == FC_CPL) ? FC_P : fc_type_t'(fct_q + 2'd1);
    nxt_vc  = (fct_q == FC_CPL) ? vc_q + 3'd1 : vc_q;
  end

  // Fields are registered so they stay frozen while the generator stalls.
  always_ff @(posedge sclk) begin
    if (!srst_n || clr) begin
      tx_valid <= 1'b0;
      tx_type  <= '0;
      tx_vc    <= '0;
      tx_hdr   <= '0;
      tx_data  <= '0;
      vc_q     <= '0;
      fct_q    <= FC_P;
      fc2_q    <= 1'b0;
    end else if (start) begin
      tx_valid <= 1'b1;
      vc_q     <= '0;
      fct_q    <= FC_P;
      fc2_q    <= fc2_sel;
      tx_type  <= initfc_code(fc2_sel, FC_P);
      tx_vc    <= '0;
      tx_hdr   <= adv_hdr[FC_P];
      tx_data  <= adv_data[FC_P];
    end else if (xfer) begin
      if (last) begin
        tx_valid <= 1'b0;
      end else begin
        vc_q    <= nxt_vc;
        fct_q   <= nxt_fct;
        tx_type <= initfc_code(fc2_q, nxt_fct);
        tx_vc   <= nxt_vc;
        tx_hdr  <= adv_hdr[nxt_fct];
        tx_data <= adv_data[nxt_fct];
      end
    end
  end
endmodule

// File: rtl/dll_fc_init_ctrl.sv
// DLCM state machine with InitFC1/InitFC2 exchange, resend timer and partner credit table.
// Optional DLL_FCI_DBG_EN adds dbg_resend_cnt_o (saturating count of timer-driven set restarts).
module dll_fc_init_ctrl
  import dll_pkg::*;
#(
  parameter int NUM_VC        = 1,
  parameter int RESEND_CYCLES = 1024,
  parameter int HDR_W         = 8,
  parameter int DATA_W        = 12
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              phy_link_up_i,
  input  logic              rx_valid_i,
  input  logic [3:0]        rx_type_i,
  input  logic [2:0]        rx_vc_i,
  input  logic [HDR_W-1:0]  rx_hdr_fc_i,
  input  logic [DATA_W-1:0] rx_data_fc_i,
  input  logic [HDR_W-1:0]  adv_ph_i,
  input  logic [HDR_W-1:0]  adv_nph_i,
  input  logic [HDR_W-1:0]  adv_cplh_i,
  input  logic [DATA_W-1:0] adv_pd_i,
  input  logic [DATA_W-1:0] adv_npd_i,
  input  logic [DATA_W-1:0] adv_cpld_i,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [3:0]        tx_type_o,
  output logic [2:0]        tx_vc_o,
  output logic [HDR_W-1:0]  tx_hdr_fc_o,
  output logic [DATA_W-1:0] tx_data_fc_o,
  input  logic [2:0]        rmt_rd_vc_i,
  input  logic [1:0]        rmt_rd_fct_i,
  output logic [HDR_W-1:0]  rmt_rd_hdr_o,
  output logic [DATA_W-1:0] rmt_rd_data_o,
  output logic [1:0]        state_o,
`ifdef DLL_FCI_DBG_EN
  output logic [15:0]       dbg_resend_cnt_o,
`endif
  output logic              link_up_o
);
  localparam int TW = $clog2(RESEND_CYCLES+1);
  localparam logic [TW-1:0] T_MAX = TW'(RESEND_CYCLES);

  dlcm_state_t state_q, state_nxt;
  logic [TW-1:0] timer_q;
  logic [NUM_VC-1:0][2:0] fi1_q;
  logic [NUM_VC-1:0]      fi2_q;
  logic [NUM_VC-1:0][2:0][HDR_W-1:0]  rmt_hdr_q;
  logic [NUM_VC-1:0][2:0][DATA_W-1:0] rmt_data_q;
  logic sent_q, started_q, in_init, chg, start, link_up_nxt, set_done;
  logic rx_fc1, rx_fc2, rx_upd, rx_live;

  assign in_init = (state_q == DL_INIT1) || (state_q == DL_INIT2);
  assign chg     = (state_nxt != state_q);
  assign state_o = state_q;

  always_ff @(posedge sclk) begin
    if (!srst_n) state_q <= DL_INACTIVE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (!phy_link_up_i) state_nxt = DL_INACTIVE;
    else begin
      case (state_q)
        DL_INACTIVE: state_nxt = DL_INIT1;
        DL_INIT1:    if ((&fi1_q) && sent_q && !tx_valid_o) state_nxt = DL_INIT2;
        DL_INIT2:    if ((&fi2_q) && sent_q && !tx_valid_o) state_nxt = DL_ACTIVE;
        default:     state_nxt = state_q;
      endcase
    end
  end

  // A set only launches from idle and never in a cycle where the state is about to move.
  always_comb begin
    start       = in_init && !chg && !tx_valid_o && (timer_q == T_MAX);
    link_up_nxt = (state_nxt == DL_ACTIVE);
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) link_up_o <= 1'b0;
    else         link_up_o <= link_up_nxt;
  end

  // Entering INIT1/INIT2 preloads the timer so the first set goes out immediately.
  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      timer_q   <= '0;
      sent_q    <= 1'b0;
      started_q <= 1'b0;
    end else if (chg) begin
      timer_q   <= (state_nxt == DL_INIT1 || state_nxt == DL_INIT2) ? T_MAX : '0;
      sent_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      if (start) begin
        timer_q   <= TW'(1);
        started_q <= 1'b1;
      end else if (in_init && timer_q != T_MAX) begin
        timer_q <= timer_q + TW'(1);
      end
      if (set_done) sent_q <= 1'b1;
    end
  end

`ifdef DLL_FCI_DBG_EN
  always_ff @(posedge sclk) begin
    if (!srst_n || !phy_link_up_i || state_q == DL_INACTIVE) dbg_resend_cnt_o <= '0;
    else if (start && started_q && dbg_resend_cnt_o != 16'hFFFF)
      dbg_resend_cnt_o <= dbg_resend_cnt_o + 16'd1;
  end
`endif

  assign rx_fc1  = (rx_type_i == INITFC1_P) || (rx_type_i == INITFC1_NP) || (rx_type_i == INITFC1_CPL);
  assign rx_fc2  = (rx_type_i == INITFC2_P) || (rx_type_i == INITFC2_NP) || (rx_type_i == INITFC2_CPL);
  assign rx_upd  = (rx_type_i == UPDATEFC_P) || (rx_type_i == UPDATEFC_NP) || (rx_type_i == UPDATEFC_CPL);
  assign rx_live = rx_valid_i && phy_link_up_i && in_init;

  // First InitFC per (vc,fct) wins; later copies never overwrite the table.
  always_ff @(posedge sclk) begin
    if (!srst_n || !phy_link_up_i) begin
      fi1_q      <= '0;
      fi2_q      <= '0;
      rmt_hdr_q  <= '0;
      rmt_data_q <= '0;
    end else if (rx_live) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (rx_vc_i == 3'(v)) begin
          for (int f = 0; f < 3; f++) begin
            if ((rx_fc1 || rx_fc2) && rx_type_i[1:0] == 2'(f) && !fi1_q[v][f]) begin
              fi1_q[v][f]      <= 1'b1;
              rmt_hdr_q[v][f]  <= rx_hdr_fc_i;
              rmt_data_q[v][f] <= rx_data_fc_i;
            end
          end
          if (rx_fc2 || rx_upd) fi2_q[v] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rmt_rd_hdr_o  = '0;
    rmt_rd_data_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      for (int f = 0; f < 3; f++) begin
        if (rmt_rd_vc_i == 3'(v) && rmt_rd_fct_i == 2'(f)) begin
          rmt_rd_hdr_o  = rmt_hdr_q[v][f];
          rmt_rd_data_o = rmt_data_q[v][f];
        end
      end
    end
  end

  dll_fci_tx_seq #(.NUM_VC(NUM_VC), .HDR_W(HDR_W), .DATA_W(DATA_W)) u_seq (
    .sclk     (sclk),
    .srst_n   (srst_n),
    .clr      (!phy_link_up_i),
    .start    (start),
    .fc2_sel  (state_q == DL_INIT2),
    .adv_hdr  ({adv_cplh_i, adv_nph_i, adv_ph_i}),
    .adv_data ({adv_cpld_i, adv_npd_i, adv_pd_i}),
    .tx_ready (tx_ready_i),
    .tx_valid (tx_valid_o),
    .tx_type  (tx_type_o),
    .tx_vc    (tx_vc_o),
    .tx_hdr   (tx_hdr_fc_o),
    .tx_data  (tx_data_fc_o),
    .set_done (set_done)
  );
endmodule
